// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the program-counter sequencer.
// Used by pc_sequencer and pc_next_sel.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_INC  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_TRAP = 3'd3,
        SEL_RET  = 3'd4
    } pc_sel_e;

    localparam int          DEFAULT_ADDR_W       = 32;
    localparam int          DEFAULT_INSTR_BYTES  = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder and mux for pc_sequencer.
// Optional target alignment checking is compiled in with PC_SEQ_ALIGN_CHECK_EN.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter int                INSTR_BYTES = DEFAULT_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] TRAP_PC     = '0
) (
    input  logic [1:0]        state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] epc,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              trap_req,
    input  logic              trap_ret,
`ifdef PC_SEQ_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic [2:0]        sel,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INSTR_BYTES);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
    logic br_mis;
    logic ret_mis;
    assign br_mis  = (branch_target & ALIGN_MASK) != '0;
    assign ret_mis = (epc & ALIGN_MASK) != '0;
`endif

    pc_sel_e sel_c;
    logic    in_run;
    logic    in_handler;

    assign in_run     = (state == RUN);
    assign in_handler = (state == TRAP);
    assign sel        = sel_c;

    always_comb begin
        sel_c = SEL_INC;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        misalign = 1'b0;
`endif
        if (!in_run && !in_handler) begin
            sel_c = SEL_HOLD;
        end else if (trap_req && in_run) begin
            sel_c = SEL_TRAP;
        end else if (trap_ret && in_handler) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            if (ret_mis) begin
                sel_c    = SEL_HOLD;
                misalign = 1'b1;
            end else begin
                sel_c = SEL_RET;
            end
`else
            sel_c = SEL_RET;
`endif
        end else if (branch_valid) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            // A bad branch target enters the handler from RUN, but only holds inside it.
            if (br_mis) begin
                misalign = 1'b1;
                if (in_run) begin
                    sel_c = SEL_TRAP;
                end else begin
                    sel_c = SEL_HOLD;
                end
            end else begin
                sel_c = SEL_BR;
            end
`else
            sel_c = SEL_BR;
`endif
        end else if (stall) begin
            sel_c = SEL_HOLD;
        end
    end

    always_comb begin
        next_pc = pc + INC;
        case (sel_c)
            SEL_HOLD: next_pc = pc;
            SEL_BR:   next_pc = branch_target;
            SEL_TRAP: next_pc = TRAP_PC;
            SEL_RET:  next_pc = epc;
            default:  next_pc = pc + INC;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, sequential/branch/trap/return selection, EPC save.
// Define PC_SEQ_ALIGN_CHECK_EN to add target alignment checking and misalign_fault.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          ADDR_W       = DEFAULT_ADDR_W,
    parameter int          INSTR_BYTES  = DEFAULT_INSTR_BYTES,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              trap_req,
    input  logic              trap_ret,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] epc,
`ifdef PC_SEQ_ALIGN_CHECK_EN
    output logic              misalign_fault,
`endif
    output logic              in_trap
);

    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] TRAP_PC  = ADDR_W'(TRAP_VECTOR);

    pc_state_e         state;
    logic [2:0]        sel;
    logic [ADDR_W-1:0] next_pc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic              misalign;
`endif

    pc_next_sel #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES),
        .TRAP_PC     (TRAP_PC)
    ) u_next_sel (
        .state         (state),
        .pc            (pc),
        .epc           (epc),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .trap_req      (trap_req),
        .trap_ret      (trap_ret),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .sel           (sel),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            epc      <= '0;
            in_trap  <= 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    // The reset vector is already on pc; leaving BOOT only qualifies it.
                    state    <= RUN;
                    pc_valid <= 1'b1;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    misalign_fault <= 1'b0;
`endif
                end
                default: begin
                    pc <= next_pc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
                    misalign_fault <= misalign;
`endif
                    if (sel == SEL_TRAP) begin
                        epc     <= pc;
                        state   <= TRAP;
                        in_trap <= 1'b1;
                    end else if (sel == SEL_RET) begin
                        state   <= RUN;
                        in_trap <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan steps plus randomized traffic
// against a behavioural model; honours PC_SEQ_ALIGN_CHECK_EN when defined.
module tb_pc_sequencer;

    localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_target = '0;
    logic        trap_req = 1'b0;
    logic        trap_ret = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] epc;
    logic        in_trap;
    logic        fault;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        misalign_fault;
    assign fault = misalign_fault;
`else
    assign fault = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_trap;
    bit          m_valid;
    bit          m_boot;
    bit          m_fault;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .trap_req      (trap_req),
        .trap_ret      (trap_ret),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .epc           (epc),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .misalign_fault(misalign_fault),
`endif
        .in_trap       (in_trap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_trap = 0; m_valid = 0; m_boot = 1; m_fault = 0;
    endtask

    function automatic bit mis(input logic [31:0] a);
        return ALIGN && (a[1:0] != 2'b00);
    endfunction

    task automatic model_step();
        m_fault = 0;
        if (!reset) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 0;
            m_valid = 1;
        end else if (trap_req && !m_trap) begin
            m_epc = m_pc; m_pc = TV; m_trap = 1;
        end else if (trap_ret && m_trap) begin
            if (mis(m_epc)) m_fault = 1;
            else begin m_pc = m_epc; m_trap = 0; end
        end else if (branch_valid) begin
            if (mis(branch_target)) begin
                m_fault = 1;
                if (!m_trap) begin m_epc = m_pc; m_pc = TV; m_trap = 1; end
            end else begin
                m_pc = branch_target;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
            check("epc", epc, m_epc);
            check("in_trap", {31'b0, in_trap}, {31'b0, m_trap});
            check("misalign_fault", {31'b0, fault}, {31'b0, m_fault});
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; branch_valid = 0; trap_req = 0; trap_ret = 0; branch_target = '0;
    endtask

    task automatic note(input string step);
        $display("step %-14s pc=%h valid=%0b epc=%h in_trap=%0b fault=%0b",
                 step, pc, pc_valid, epc, in_trap, fault);
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_pc", pc, 32'h0);
        check("reset_valid", {31'b0, pc_valid}, 32'h0);
        check("reset_epc", epc, 32'h0);
        check("reset_in_trap", {31'b0, in_trap}, 32'h0);
        note("reset");
        reset = 1;
        chk_en = 1;

        // Boot sequence
        cyc(); check("boot_pc0", pc, 32'h0); check("boot_valid", {31'b0, pc_valid}, 32'h1); note("boot");
        cyc(); check("boot_pc4", pc, 32'h4); note("inc");
        cyc(); check("boot_pc8", pc, 32'h8); note("inc");
        cyc(); cyc(); check("pc_10", pc, 32'h10); note("inc");

        // Stall versus branch
        stall = 1;
        for (int i = 0; i < 3; i++) begin cyc(); check("stall_hold", pc, 32'h10); note("stall"); end
        branch_valid = 1; branch_target = 32'h1000_0000;
        cyc(); check("branch_over_stall", pc, 32'h1000_0000); note("br+stall");
        idle();

        // Trap round trip
        branch_valid = 1; branch_target = 32'h20;
        cyc(); idle(); check("pc_20", pc, 32'h20);
        trap_req = 1;
        cyc(); idle();
        check("trap_pc", pc, 32'h100); check("trap_epc", epc, 32'h20);
        check("trap_flag", {31'b0, in_trap}, 32'h1); note("trap");
        cyc(); cyc(); check("handler_108", pc, 32'h108); note("handler");
        trap_ret = 1;
        cyc(); idle(); check("ret_pc", pc, 32'h20); check("ret_flag", {31'b0, in_trap}, 32'h0); note("ret");

        // Nested and ignored requests
        trap_req = 1;
        cyc(); idle();
        trap_req = 1; branch_valid = 1; branch_target = 32'h200;
        cyc(); idle();
        check("nested_pc", pc, 32'h200); check("nested_epc", epc, 32'h20); note("nested");
        trap_ret = 1;
        cyc(); idle(); check("ret2_pc", pc, 32'h20);
        trap_ret = 1;
        cyc(); idle(); check("ignored_ret", pc, 32'h24); check("ignored_flag", {31'b0, in_trap}, 32'h0); note("ret_in_run");

        // Wrap-around
        branch_valid = 1; branch_target = 32'hFFFF_FFFC;
        cyc(); idle(); check("wrap_pre", pc, 32'hFFFF_FFFC);
        cyc(); check("wrap_post", pc, 32'h0); note("wrap");

        // Asynchronous reset while in the handler
        trap_req = 1;
        cyc(); idle();
        cyc(); check("pre_reset_pc", pc, 32'h104);
        #2 reset = 0;
        #1;
        check("async_pc", pc, 32'h0); check("async_trap", {31'b0, in_trap}, 32'h0);
        check("async_epc", epc, 32'h0); check("async_valid", {31'b0, pc_valid}, 32'h0);
        model_reset();
        note("async_reset");
        @(negedge clk); reset = 1;
        cyc(); check("reboot_pc", pc, 32'h0); check("reboot_valid", {31'b0, pc_valid}, 32'h1);

`ifdef PC_SEQ_ALIGN_CHECK_EN
        cyc();
        branch_valid = 1; branch_target = 32'h2;
        cyc(); idle();
        check("align_pc", pc, 32'h100); check("align_fault", {31'b0, fault}, 32'h1);
        check("align_epc", epc, 32'h4); note("misalign");
        cyc(); check("align_pulse", {31'b0, fault}, 32'h0);
        trap_ret = 1; cyc(); idle();
`endif

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            stall        = ($urandom_range(3) == 0);
            branch_valid = ($urandom_range(7) == 0);
            trap_req     = ($urandom_range(15) == 0);
            trap_ret     = ($urandom_range(7) == 0);
            branch_target = $urandom();
            if (!ALIGN || $urandom_range(3) != 0) branch_target[1:0] = 2'b00;
            if ($urandom_range(149) == 0) begin
                #2 reset = 0;
                #1 model_reset();
                cyc();
                reset = 1;
            end else begin
                cyc();
            end
            note("random");
        end
        idle();
        cyc();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
